// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access unit.
//   - size encodings for the DataPath request
//   - FSM state encoding (IDLE / XFER / DONE)
//   - helpers: byte count per size and the misalignment rule
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of single-byte RAM cycles a request needs. The reserved size
  // never reaches XFER, so its count of 0 is never used for a transfer.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      SZ_WORD: byte_count = 3'd4;
      default: byte_count = 3'd0;
    endcase
  endfunction

  // A request is rejected when its address is not a multiple of its size,
  // or when it uses the reserved size encoding.
  function automatic logic bad_request(input logic [1:0] size,
                                       input logic [1:0] addr_lsb);
    case (size)
      SZ_BYTE: bad_request = 1'b0;
      SZ_HALF: bad_request = addr_lsb[0];
      SZ_WORD: bad_request = (addr_lsb != 2'b00);
      default: bad_request = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_pack.sv
// byte_lane_pack: combinational byte steering for the memory access unit.
//   Load side : packs the captured big-endian bytes into a right-justified
//               32-bit value and sign/zero-extends byte and halfword loads.
//   Store side: picks store byte k out of the right-justified store data,
//               byte 0 being the most significant byte of the N-byte field.
// Ports:
//   cap        captured load bytes, byte k at cap[31-8k -: 8]
//   size       access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext   1 = sign-extend byte/halfword loads
//   load_data  packed and extended load result
//   store_data right-justified store data
//   store_idx  store byte index k (0..N-1)
//   store_byte selected store byte
module byte_lane_pack
  import mem_pkg::*;
(
  input  logic [31:0] cap,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  input  logic [31:0] store_data,
  input  logic [1:0]  store_idx,
  output logic [7:0]  store_byte
);

  logic [31:0] store_left;

  always_comb begin
    load_data = cap;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & cap[31]}}, cap[31:24]};
      SZ_HALF: load_data = {{16{sign_ext & cap[31]}}, cap[31:16]};
      default: load_data = cap;
    endcase
  end

  // Left-justify the N-byte store field so byte k is always at 31-8k.
  always_comb begin
    store_left = store_data;
    case (size)
      SZ_BYTE: store_left = {store_data[7:0], 24'h0};
      SZ_HALF: store_left = {store_data[15:0], 16'h0};
      default: store_left = store_data;
    endcase
  end

  always_comb begin
    store_byte = store_left[31:24];
    case (store_idx)
      2'd0:    store_byte = store_left[31:24];
      2'd1:    store_byte = store_left[23:16];
      2'd2:    store_byte = store_left[15:8];
      default: store_byte = store_left[7:0];
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges the DataPath memory port (MAR/DataIn/RW/MOV ->
// DataOut/MOC) to a byte-wide synchronous RAM, splitting byte, halfword and
// word requests into single-byte RAM cycles in big-endian order.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   MOV, RW, size,      request: valid level, 1=read/0=write, size code,
//   sign_ext, MAR,      load extension, byte address, right-justified
//   DataIn              store data
//   DataOut, MOC, err   registered load result, completion, error flag
//   ram_addr, ram_wdata RAM byte address and write byte
//   ram_we, ram_re      RAM write / read enable (never both high)
//   ram_rdata           RAM read byte, valid the cycle after ram_re
//   dbg_state           current FSM state (state_t encoding)
//
// Handshake: MOV is a level request held (with MAR/DataIn stable) until MOC
// is seen. The request is accepted on the edge where MOV=1 in IDLE; MOC then
// stays high while MOV is high, and MOV=0 at an edge returns to IDLE. If MOV
// falls during XFER the transfer still completes and MOC pulses one cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] MAR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              MOC,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        dbg_state
);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sx_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       cap_q;

  logic [2:0]        n_q;
  logic [2:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       cap_next;
  logic [1:0]        pack_size;
  logic [31:0]       pack_store;
  logic [1:0]        pack_idx;
  logic [31:0]       load_data;
  logic [7:0]        store_byte;

  // Address bits above the RAM width are ignored (address wraps).
  logic unused_mar_hi;
  assign unused_mar_hi = ^MAR[DATA_W-1:ADDR_W];

  assign n_q       = byte_count(size_q);
  assign cnt_inc   = cnt_q + 3'd1;
  assign addr_next = base_q + ADDR_W'(cnt_inc);
  assign dbg_state = state_q;

  // The byte arriving now (for cnt=k>=1 it is byte k-1) is merged in before
  // packing, so DataOut can be loaded on the same edge that captures the
  // last byte.
  always_comb begin
    cap_next = cap_q;
    case (cnt_q)
      3'd1:    cap_next[31:24] = ram_rdata;
      3'd2:    cap_next[23:16] = ram_rdata;
      3'd3:    cap_next[15:8]  = ram_rdata;
      3'd4:    cap_next[7:0]   = ram_rdata;
      default: cap_next = cap_q;
    endcase
  end

  // In IDLE the steering works on the incoming request (store byte 0 is
  // launched on the accepting edge); afterwards it works on the latched one
  // and looks one byte ahead because RAM outputs are registered.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pack_size  = size;
      pack_store = DataIn;
      pack_idx   = 2'd0;
    end else begin
      pack_size  = size_q;
      pack_store = wdata_q;
      pack_idx   = cnt_inc[1:0];
    end
  end

  byte_lane_pack u_pack (
    .cap        (cap_next),
    .size       (pack_size),
    .sign_ext   (sx_q),
    .load_data  (load_data),
    .store_data (pack_store),
    .store_idx  (pack_idx),
    .store_byte (store_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      rw_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      sx_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= 32'h0;
      cap_q     <= 32'h0;
      DataOut   <= '0;
      MOC       <= 1'b0;
      err       <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'h0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MOV) begin
            rw_q    <= RW;
            size_q  <= size;
            sx_q    <= sign_ext;
            base_q  <= MAR[ADDR_W-1:0];
            wdata_q <= DataIn;
            cap_q   <= 32'h0;
            cnt_q   <= 3'd0;
            if (bad_request(size, MAR[1:0])) begin
              state_q <= ST_DONE;
              MOC     <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_q  <= ST_XFER;
              err      <= 1'b0;
              ram_addr <= MAR[ADDR_W-1:0];
              if (RW) begin
                ram_re <= 1'b1;
              end else begin
                ram_we    <= 1'b1;
                ram_wdata <= store_byte;
              end
            end
          end
        end

        ST_XFER: begin
          cnt_q <= cnt_inc;
          if (rw_q) begin
            // Read: N issue cycles plus one trailing capture cycle.
            cap_q <= cap_next;
            if (cnt_inc < n_q) begin
              ram_re   <= 1'b1;
              ram_addr <= addr_next;
            end else begin
              ram_re <= 1'b0;
            end
            if (cnt_q == n_q) begin
              state_q <= ST_DONE;
              MOC     <= 1'b1;
              DataOut <= load_data;
            end
          end else begin
            if (cnt_inc < n_q) begin
              ram_we    <= 1'b1;
              ram_addr  <= addr_next;
              ram_wdata <= store_byte;
            end else begin
              ram_we  <= 1'b0;
              state_q <= ST_DONE;
              MOC     <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          if (!MOV) begin
            state_q <= ST_IDLE;
            MOC     <= 1'b0;
            err     <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          MOC     <= 1'b0;
          err     <= 1'b0;
          ram_we  <= 1'b0;
          ram_re  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit. A behavioural
// RAM sits on the byte port; a byte-array reference model tracks what the RAM
// should hold and what each load should return.
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        MOV, RW, sign_ext;
  logic [1:0]  size;
  logic [31:0] MAR, DataIn, DataOut;
  logic        MOC, err;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
  logic [1:0]  dbg_state;

  mem_access_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .size(size),
    .sign_ext(sign_ext), .MAR(MAR), .DataIn(DataIn), .DataOut(DataOut),
    .MOC(MOC), .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- RAM environment ----------------
  logic [7:0] ram [512];
  logic [7:0] ref_mem [512];
  logic       ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 512; i++) ram[i] <= ref_mem[i];
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram[ram_addr];
    end
  end

  // ---------------- scoreboard / model ----------------
  int          tests_run = 0;
  int          failures  = 0;
  logic [31:0] model_dout = 32'h0;
  logic [31:0] exp_q [$];

  function automatic int model_n(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] mar);
    if (sz == 2'b11) return 1'b1;
    return (mar % model_n(sz)) != 0;
  endfunction

  task automatic model_store(input logic [31:0] mar, input logic [1:0] sz,
                             input logic [31:0] din);
    int n = model_n(sz);
    for (int k = 0; k < n; k++)
      ref_mem[(mar + 32'(k)) % 32'd512] = 8'((din >> (8 * (n - 1 - k))) & 32'hFF);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] mar,
                                             input logic [1:0] sz, input logic sx);
    int    n = model_n(sz);
    longint v = 0;
    for (int k = 0; k < n; k++)
      v = v * 256 + longint'(ref_mem[(mar + 32'(k)) % 32'd512]);
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  int obs_lat, obs_we, obs_re, obs_both, obs_err, obs_hold_moc, obs_hold_act, obs_after;

  // Presents one request, waits (bounded) for MOC, optionally holds MOV for
  // hold cycles in DONE, then drops MOV and samples MOC one edge later.
  task automatic run_access(input logic rw, input logic [1:0] sz, input logic sx,
                            input logic [31:0] mar, input logic [31:0] din,
                            input int hold);
    @(negedge clk);
    MOV = 1'b1; RW = rw; size = sz; sign_ext = sx; MAR = mar; DataIn = din;
    obs_lat = 0; obs_we = 0; obs_re = 0; obs_both = 0; obs_err = 0;
    obs_hold_moc = 1; obs_hold_act = 0;
    @(posedge clk);                       // accepting edge
    for (int c = 1; c <= 20; c++) begin
      #1;
      obs_lat = c;
      obs_we += int'(ram_we);
      obs_re += int'(ram_re);
      if (ram_we && ram_re) obs_both++;
      if (MOC) begin
        obs_err = int'(err);
        break;
      end
      @(posedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!MOC) obs_hold_moc = 0;
      if (ram_we || ram_re) obs_hold_act++;
    end
    @(negedge clk);
    MOV = 1'b0;
    @(posedge clk); #1;
    obs_after = int'(MOC);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; MOV = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({DataOut, MOC, err} !== 34'h0) begin
      failures++;
      $display("FAIL reset_out: DataOut=%h MOC=%b err=%b required 0/0/0", DataOut, MOC, err);
    end
    tests_run++;
    if ({ram_we, ram_re, ram_addr, ram_wdata} !== 19'h0) begin
      failures++;
      $display("FAIL reset_ram: we=%b re=%b addr=%h wdata=%h required all 0",
               ram_we, ram_re, ram_addr, ram_wdata);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d required 0 (IDLE)", dbg_state);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_word_store();
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h11223344, 0);
    model_store(32'h10, 2'b10, 32'h11223344);
    tests_run++;
    if (obs_lat != 5 || obs_err != 0) begin
      failures++;
      $display("FAIL word_store_lat: lat=%0d err=%0d required 5/0", obs_lat, obs_err);
    end
    tests_run++;
    if (obs_we != 4 || obs_re != 0) begin
      failures++;
      $display("FAIL word_store_we: we=%0d re=%0d required 4/0", obs_we, obs_re);
    end
    tests_run++;
    if ({ram[16], ram[17], ram[18], ram[19]} !== 32'h11223344) begin
      failures++;
      $display("FAIL word_store_ram: got %h%h%h%h required 11223344",
               ram[16], ram[17], ram[18], ram[19]);
    end
    tests_run++;
    if (obs_after != 0) begin
      failures++;
      $display("FAIL word_store_release: MOC=%0d after MOV low, required 0", obs_after);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] d;
    d = {$urandom_range(0, 32'hFFFFFF), 8'h84};
    run_access(1'b0, 2'b00, 1'b0, 32'h13, d, 0);
    model_store(32'h13, 2'b00, d);
    tests_run++;
    if (obs_lat != 2 || obs_we != 1) begin
      failures++;
      $display("FAIL byte_store: lat=%0d we=%0d required 2/1", obs_lat, obs_we);
    end
    run_access(1'b1, 2'b00, 1'b1, 32'h13, $urandom, 0);
    model_dout = model_load(32'h13, 2'b00, 1'b1);
    tests_run++;
    if (DataOut !== 32'hFFFFFF84 || DataOut !== model_dout || obs_lat != 3) begin
      failures++;
      $display("FAIL byte_load_sx: DataOut=%h lat=%0d required FFFFFF84 (model %h) lat 3",
               DataOut, obs_lat, model_dout);
    end
    run_access(1'b1, 2'b00, 1'b0, 32'h13, $urandom, 0);
    model_dout = model_load(32'h13, 2'b00, 1'b0);
    tests_run++;
    if (DataOut !== 32'h00000084 || DataOut !== model_dout || obs_lat != 3 || obs_re != 1) begin
      failures++;
      $display("FAIL byte_load_zx: DataOut=%h lat=%0d re=%0d required 00000084 lat 3 re 1",
               DataOut, obs_lat, obs_re);
    end
    d = {$urandom_range(0, 32'hFFFF), 16'h8001};
    run_access(1'b0, 2'b01, 1'b0, 32'h12, d, 0);
    model_store(32'h12, 2'b01, d);
    run_access(1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    model_dout = model_load(32'h12, 2'b01, 1'b1);
    tests_run++;
    if (DataOut !== 32'hFFFF8001 || DataOut !== model_dout || obs_lat != 4) begin
      failures++;
      $display("FAIL half_load_sx: DataOut=%h lat=%0d required FFFF8001 lat 4", DataOut, obs_lat);
    end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 2'b01, 1'b0, 32'h11, 32'hDEAD5A5A, 0);
    tests_run++;
    if (obs_lat != 1 || obs_err != 1 || obs_we != 0 || obs_re != 0 || DataOut !== model_dout) begin
      failures++;
      $display("FAIL misalign_half_store: lat=%0d err=%0d we=%0d re=%0d DataOut=%h required 1/1/0/0/%h",
               obs_lat, obs_err, obs_we, obs_re, DataOut, model_dout);
    end
    run_access(1'b1, 2'b10, 1'b1, 32'h22, 32'h0, 0);
    tests_run++;
    if (obs_lat != 1 || obs_err != 1 || obs_we != 0 || obs_re != 0 || DataOut !== model_dout) begin
      failures++;
      $display("FAIL misalign_word_load: lat=%0d err=%0d we=%0d re=%0d DataOut=%h required 1/1/0/0/%h",
               obs_lat, obs_err, obs_we, obs_re, DataOut, model_dout);
    end
    tests_run++;
    if (ram[17] !== ref_mem[17] || ram[18] !== ref_mem[18]) begin
      failures++;
      $display("FAIL misalign_ram: got %h %h required %h %h", ram[17], ram[18], ref_mem[17], ref_mem[18]);
    end
    run_access(1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 0);
    tests_run++;
    if (obs_lat != 1 || obs_err != 1 || obs_re != 0) begin
      failures++;
      $display("FAIL reserved_size: lat=%0d err=%0d re=%0d required 1/1/0", obs_lat, obs_err, obs_re);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    MOV = 1'b1; RW = 1'b0; size = 2'b10; sign_ext = 1'b0; MAR = 32'h20; DataIn = 32'hAABBCCDD;
    @(posedge clk);                       // accepting edge
    @(posedge clk);                       // first byte written
    @(negedge clk);
    reset = 1'b1; MOV = 1'b0;
    @(posedge clk); #1;                   // second byte written, reset taken
    ref_mem[32] = 8'hAA;
    ref_mem[33] = 8'hBB;
    model_dout = 32'h0;
    tests_run++;
    if (MOC !== 1'b0 || DataOut !== 32'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_write_out: MOC=%b DataOut=%h state=%0d required 0/0/0", MOC, DataOut, dbg_state);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ram[32], ram[33], ram[34], ram[35]} !== {ref_mem[32], ref_mem[33], ref_mem[34], ref_mem[35]}) begin
      failures++;
      $display("FAIL reset_mid_write_ram: got %h%h%h%h required %h%h%h%h",
               ram[32], ram[33], ram[34], ram[35], ref_mem[32], ref_mem[33], ref_mem[34], ref_mem[35]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom;
    run_access(1'b0, 2'b10, 1'b0, 32'h200, d, 0);
    model_store(32'h200, 2'b10, d);
    tests_run++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== d) begin
      failures++;
      $display("FAIL wrap_store: got %h%h%h%h required %h", ram[0], ram[1], ram[2], ram[3], d);
    end
    d = $urandom;
    run_access(1'b0, 2'b10, 1'b0, 32'h1FC, d, 0);
    model_store(32'h1FC, 2'b10, d);
    run_access(1'b1, 2'b10, 1'b1, 32'hFFFF_F1FC, 32'h0, 0);
    model_dout = model_load(32'h1FC, 2'b10, 1'b1);
    tests_run++;
    if (DataOut !== model_dout || DataOut !== d || obs_lat != 6 || obs_re != 4) begin
      failures++;
      $display("FAIL wrap_load: DataOut=%h lat=%0d re=%0d required %h lat 6 re 4",
               DataOut, obs_lat, obs_re, model_dout);
    end
  endtask

  task automatic test_mov_drop();
    int moc_cycles = 0, first = 0;
    @(negedge clk);
    MOV = 1'b1; RW = 1'b1; size = 2'b10; sign_ext = 1'b0; MAR = 32'h10; DataIn = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (MOC) begin
        moc_cycles++;
        if (first == 0) first = c;
      end
      if (c == 2) begin
        @(negedge clk);
        MOV = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    model_dout = model_load(32'h10, 2'b10, 1'b0);
    tests_run++;
    if (moc_cycles != 1 || first != 6) begin
      failures++;
      $display("FAIL mov_drop_pulse: MOC cycles=%0d first=%0d required 1 at 6", moc_cycles, first);
    end
    tests_run++;
    if (DataOut !== model_dout || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mov_drop_data: DataOut=%h state=%0d required %h state 0", DataOut, dbg_state, model_dout);
    end
  endtask

  task automatic test_mov_hold();
    logic [31:0] d;
    d = $urandom;
    run_access(1'b0, 2'b01, 1'b0, 32'h0A0, d, 6);
    model_store(32'h0A0, 2'b01, d);
    tests_run++;
    if (obs_hold_moc != 1 || obs_hold_act != 0 || obs_we != 2 || obs_after != 0) begin
      failures++;
      $display("FAIL mov_hold: moc_held=%0d extra_ram_cycles=%0d we=%0d after=%0d required 1/0/2/0",
               obs_hold_moc, obs_hold_act, obs_we, obs_after);
    end
  endtask

  task automatic test_back_to_back_random();
    logic        rw, sx;
    logic [1:0]  sz;
    logic [31:0] mar, din, exp_d;
    int          n, exp_lat, bad, mism;
    for (int it = 0; it < 40; it++) begin
      rw  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      mar = $urandom;
      din = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) mar = mar & ~32'(model_n(sz) - 1);
      n   = model_n(sz);
      bad = int'(model_bad(sz, mar));
      if (bad != 0) exp_lat = 1;
      else if (rw) exp_lat = n + 2;
      else exp_lat = n + 1;
      if (bad == 0 && rw) model_dout = model_load(mar, sz, sx);
      exp_q.push_back(model_dout);
      run_access(rw, sz, sx, mar, din, 0);
      if (bad == 0 && !rw) model_store(mar, sz, din);
      exp_d = exp_q.pop_front();
      tests_run++;
      if (obs_lat != exp_lat || obs_err != bad || DataOut !== exp_d || obs_both != 0) begin
        failures++;
        $display("FAIL random[%0d] rw=%b sz=%0d mar=%h: lat=%0d err=%0d DataOut=%h overlap=%0d required lat=%0d err=%0d DataOut=%h",
                 it, rw, sz, mar, obs_lat, obs_err, DataOut, obs_both, exp_lat, bad, exp_d);
      end
    end
    mism = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) mism++;
    tests_run++;
    if (mism != 0) begin
      failures++;
      $display("FAIL ram_image: %0d bytes differ from model, required 0", mism);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1; MOV = 1'b0; RW = 1'b0; size = 2'b00; sign_ext = 1'b0;
    MAR = 32'h0; DataIn = 32'h0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ram_load = 1'b1;
    @(posedge clk);
    @(negedge clk); ram_load = 1'b0;

    test_reset();
    test_word_store();
    test_byte_loads();
    test_misaligned();
    test_reset_mid_write();
    test_wrap();
    test_mov_drop();
    test_mov_hold();
    test_back_to_back_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory access controller between the DataPath memory port (MAR, DataIn, RW, MOV → DataOut, MOC) and a byte-wide 512x8 synchronous RAM array. It converts one byte, halfword or word request into a sequence of single-byte RAM cycles. The byte order is big-endian (MIPS). It returns sign- or zero-extended load data and signals completion through the MOV/MOC handshake. Misaligned accesses are flagged instead of performed.

Parameters:
ADDR_W, 9, RAM byte-address width; MAR bits above ADDR_W-1 are ignored (address wraps modulo 2^ADDR_W).
DATA_W, 32, DataPath word width; fixed at 32, the parameter is for documentation and assertions only.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
MOV  input  1  memory operation valid (level); must stay high until MOC is seen
RW  input  1  1 = read (load), 0 = write (store)
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
MAR  input  32  byte address; stable while MOV is high
DataIn  input  32  store data, right-justified; stable while MOV is high
DataOut  output  32  load result, registered
MOC  output  1  memory operation complete
err  output  1  misaligned or reserved-size request; valid while MOC is high
ram_addr  output  ADDR_W  RAM byte address
ram_wdata  output  8  RAM write byte
ram_we  output  1  RAM write enable
ram_re  output  1  RAM read enable; data returns on ram_rdata one cycle later
ram_rdata  input  8  RAM read byte

Behaviour:
- Reset (sync, active-high) clears state to IDLE and drives DataOut=0, MOC=0, err=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0. Reset overrides every other condition.
- Reset during XFER aborts the access. Bytes already written stay in the RAM. No MOC is produced.
- Byte count N: byte 1, halfword 2, word 4.
- States: IDLE, XFER, DONE.
- IDLE: MOV=1 sampled at an edge causes the request to be checked.
  - Misaligned (halfword with MAR[0]=1, word with MAR[1:0]≠0) or size=11: go to DONE with err=1 and no RAM access.
  - Otherwise: go to XFER with cnt=0 and err=0.
- XFER, write: in the cycle with cnt=k (0..N-1), ram_we=1, ram_addr=MAR[ADDR_W-1:0]+k (wraps), ram_wdata = store byte k.
  - Store byte 0 is the most significant byte of the N-byte field: word DataIn[31:24]; half DataIn[15:8]; byte DataIn[7:0].
  - After cnt=N-1, go to DONE. This takes N cycles.
- XFER, read: in the cycle with cnt=k<N, ram_re=1 and ram_addr=base+k. In the cycle with cnt=k≥1, ram_rdata is captured as byte k-1.
  - There are N+1 cycles. DataOut is loaded (packed and extended) on the edge leaving XFER.
- Latency, counted from the MOV-accepting edge to MOC high: write N+1 cycles; read N+2 cycles; error 1 cycle.
- DONE: MOC=1. DataOut holds until the next read completes, so writes and errors do not change it. ram_we=0 and ram_re=0.
  - The state stays in DONE while MOV=1. MOV=0 at an edge returns to IDLE, clearing MOC and err.
- MOV dropping during XFER does not abort the access. The transfer completes, MOC pulses for one cycle, then the state returns to IDLE.
- Back-to-back accesses require at least one cycle with MOV=0. A new request is only accepted in IDLE.
- Extension: byte loads use bit 7 as the sign; halfword loads use bit 15. A word load ignores sign_ext.
- ram_re and ram_we are never high in the same cycle.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state encoding for IDLE, XFER and DONE;
  - a function giving the byte count N from size.
- One sub-module, byte_lane_pack. It is purely combinational and takes the 4 captured bytes, size and sign_ext and produces the 32-bit extended result. It also selects the store byte for a given cnt.
- mem_access_unit holds the FSM, the counter, the capture registers and the RAM port.

Test Plan:
- Word store: MAR=0x10, DataIn=0x11223344, RW=0. Required: RAM[0x10..0x13]=11,22,33,44; ram_we high for exactly 4 cycles; MOC high 5 cycles after acceptance; err=0.
- Byte loads of RAM[0x13]=0x84:
  - sign_ext=1 gives DataOut=0xFFFFFF84.
  - sign_ext=0 gives DataOut=0x00000084.
  - MOC arrives 3 cycles after acceptance.
  - A halfword load at 0x12 with RAM[0x12..0x13]=0x80,0x01 and sign_ext=1 gives DataOut=0xFFFF8001.
- Misalignment: halfword store at MAR=0x11 and word load at MAR=0x22. Required for each: MOC after 1 cycle with err=1, ram_we and ram_re never asserted, DataOut unchanged.
- Reset mid-write: word store 0xAABBCCDD at 0x20, reset asserted after 2 XFER cycles. Required: RAM[0x20]=AA, RAM[0x21]=BB, RAM[0x22..0x23] unchanged; MOC=0, DataOut=0, state IDLE.
- Wrap and handshake:
  - A word store at MAR=0x200 writes RAM[0x000..0x003].
  - A word load at 0x1FC returns the correct data.
  - If MOV drops mid-XFER, the transfer completes with a single-cycle MOC pulse.
  - If MOV is held high through DONE, MOC stays high and no second access starts.
